sram1r1w_fifo_ctrl: RTL and testbench
=====================================

Name: sram1r1w_fifo_ctrl

Overview:
Valid/ready FIFO controller that owns one sram1r1w instance (N words x W bits, 1-cycle registered read) and sits directly in front of it. It turns push/pop handshakes into SRAM write/read strobes and addresses. It hides the SRAM read latency with a 3-entry output prefetch buffer, so pop throughput is one word per cycle. Total capacity is N + 3 words.

Parameters:
N, 16, SRAM word count; any integer >= 2 (need not be a power of two); pointers wrap explicitly at N-1.
W, 32, data width in bits.

Ports:
clk  in  1  clock; all state updates on posedge.
arst_n  in  1  reset; asynchronous, active-low.
i_push_vld  in  1  producer has a word.
i_push_data  in  W  producer word.
o_push_rdy  out  1  controller can accept a word.
o_pop_vld  out  1  head word is valid.
o_pop_data  out  W  head word.
i_pop_rdy  in  1  consumer accepts the head word.
o_sram_wen  out  1  SRAM write enable.
o_sram_waddr  out  $clog2(N)  SRAM write address.
o_sram_wdata  out  W  SRAM write data.
o_sram_ren  out  1  SRAM read enable.
o_sram_raddr  out  $clog2(N)  SRAM read address.
i_sram_rdata  in  W  SRAM read data; valid the cycle after o_sram_ren.

Behaviour:
- Reset (arst_n=0, asynchronous):
  - wptr=0, rptr=0, sram_cnt=0, inflight=0, obuf_cnt=0.
  - Outputs during and after reset: o_pop_vld=0, o_sram_wen=0, o_sram_ren=0, o_push_rdy=1.
  - Reset asserted mid-operation discards all stored and in-flight words. SRAM contents are not cleared and are never read before being rewritten.
- Push:
  - push = i_push_vld & o_push_rdy.
  - o_push_rdy = (sram_cnt != N); combinational from registered state only, never from i_push_vld.
  - o_sram_wen = push; o_sram_waddr = wptr; o_sram_wdata = i_push_data (combinational pass-through).
  - wptr advances on push, wrapping N-1 -> 0.
- Prefetch read:
  - ren = (sram_cnt != 0) & (obuf_cnt + inflight - pop < 3), where pop = o_pop_vld & i_pop_rdy.
  - o_sram_ren = ren; o_sram_raddr = rptr. rptr advances on ren, wrapping N-1 -> 0.
  - inflight <= ren (1-bit register).
  - When inflight=1, i_sram_rdata is written into obuf at the end of that cycle.
- sram_cnt update: +1 on push only; -1 on ren only; unchanged when both or neither occur. A word written in cycle t is eligible for read no earlier than t+1, so a same-cycle read/write of the same address never occurs.
- Output buffer:
  - 3-entry circular buffer; obuf_cnt range 0..3.
  - o_pop_vld = (obuf_cnt != 0); o_pop_data = head entry.
  - Simultaneous capture and pop: count unchanged, head advances.
  - Overflow is impossible by the credit rule; the bench asserts obuf_cnt <= 3 and !(capture & obuf_cnt==3 & !pop).
- Latency: push handshake in cycle t -> ren t+1 -> capture t+2 -> o_pop_vld=1 in t+3, provided the buffer was empty.
- Throughput: sustained 1 push + 1 pop per cycle indefinitely once primed.
- Order: strict FIFO. Data are never dropped or duplicated.
- Full condition: o_push_rdy=0 when sram_cnt=N (total occupancy is N + obuf_cnt + inflight).
- A pop in the same cycle as the full condition does not raise o_push_rdy combinationally; ready rises the cycle after a ren frees a slot.
- Fill/drain: when i_pop_rdy=0, the obuf fills to 3 and then the SRAM fills to N.

Test Plan:
- Reset/idle: hold arst_n=0 for 3 cycles mid-clock, then release -> o_pop_vld=0, o_push_rdy=1, no wen/ren strobes; drop arst_n asynchronously mid-burst -> all outputs return to reset values immediately.
- Single word latency (N=16, W=32): push 0xDEADBEEF in cycle 0 with i_pop_rdy=1 -> wen/waddr=0 in cycle 0, ren/raddr=0 in cycle 1, o_pop_vld=1 with 0xDEADBEEF in cycle 3.
- Fill to full: i_pop_rdy=0, push 0..18 -> exactly 19 words accepted (16+3), o_push_rdy=0 after the 19th; then pop all -> values 0..18 in order, o_pop_vld=0 afterwards.
- Streaming: push and pop every cycle for 200 words with an incrementing pattern -> after the 3-cycle prime, one pop per cycle with no bubbles; the output sequence equals the input sequence.
- Pointer wrap with non-power-of-two depth (N=5): stream 23 words with random i_pop_rdy / i_push_vld stalls -> waddr/raddr wrap 4->0, data in order, no loss or duplication.
- Simultaneous full/pop: at full, assert pop and push in the same cycle -> push is not accepted that cycle, o_push_rdy=1 the next cycle, and sram_cnt/obuf_cnt stay consistent per the scoreboard.

Source files
------------

// File: rtl/sram1r1w_fifo_ctrl.sv
// Valid/ready FIFO controller in front of a 1R1W SRAM (1-cycle registered read).
// A 3-entry prefetch buffer hides the read latency so pops run at one word per cycle.
module sram1r1w_fifo_ctrl #(
  parameter int N = 16,
  parameter int W = 32,
  localparam int AW = (N > 1) ? $clog2(N) : 1,
  localparam int CW = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          arst_n,
  input  logic          i_push_vld,
  input  logic [W-1:0]  i_push_data,
  output logic          o_push_rdy,
  output logic          o_pop_vld,
  output logic [W-1:0]  o_pop_data,
  input  logic          i_pop_rdy,
  output logic          o_sram_wen,
  output logic [AW-1:0] o_sram_waddr,
  output logic [W-1:0]  o_sram_wdata,
  output logic          o_sram_ren,
  output logic [AW-1:0] o_sram_raddr,
  input  logic [W-1:0]  i_sram_rdata
);

  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] sram_cnt;
  logic          inflight;
  logic [1:0]    obuf_cnt, head, tail;
  logic [W-1:0]  obuf [3];
  logic          push, pop, ren;
  logic [2:0]    credit;

  assign o_push_rdy   = (sram_cnt != CW'(N));
  assign push         = i_push_vld & o_push_rdy;
  assign o_pop_vld    = (obuf_cnt != 2'd0);
  assign o_pop_data   = obuf[head];
  assign pop          = o_pop_vld & i_pop_rdy;

  // Words already buffered or on their way, minus the one leaving this cycle.
  assign credit       = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, pop};
  assign ren          = (sram_cnt != '0) && (credit < 3'd3);

  assign o_sram_wen   = push;
  assign o_sram_waddr = wptr;
  assign o_sram_wdata = i_push_data;
  assign o_sram_ren   = ren;
  assign o_sram_raddr = rptr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      sram_cnt <= '0;
      inflight <= 1'b0;
      obuf_cnt <= 2'd0;
      head     <= 2'd0;
      tail     <= 2'd0;
    end else begin
      if (push) wptr <= (wptr == AW'(N - 1)) ? '0 : wptr + AW'(1);
      if (ren)  rptr <= (rptr == AW'(N - 1)) ? '0 : rptr + AW'(1);
      case ({push, ren})
        2'b10:   sram_cnt <= sram_cnt + CW'(1);
        2'b01:   sram_cnt <= sram_cnt - CW'(1);
        default: sram_cnt <= sram_cnt;
      endcase
      inflight <= ren;
      if (inflight) tail <= (tail == 2'd2) ? 2'd0 : tail + 2'd1;
      if (pop)      head <= (head == 2'd2) ? 2'd0 : head + 2'd1;
      case ({inflight, pop})
        2'b10:   obuf_cnt <= obuf_cnt + 2'd1;
        2'b01:   obuf_cnt <= obuf_cnt - 2'd1;
        default: obuf_cnt <= obuf_cnt;
      endcase
    end
  end

  // Payload storage needs no reset; obuf_cnt gates visibility.
  always_ff @(posedge clk) begin
    if (inflight) obuf[tail] <= i_sram_rdata;
  end

endmodule

// File: tb/tb_sram1r1w_fifo_ctrl.sv
// Directed bench for sram1r1w_fifo_ctrl: N=16 instance for latency/fill/stream/reset,
// N=5 instance for pointer wrap under random stalls. Both backed by behavioural SRAMs.
module tb_sram1r1w_fifo_ctrl;
  localparam int W = 32;

  logic clk = 1'b0;
  logic arst_n;
  always #5 clk = ~clk;

  // ---- instance A: N=16
  logic         a_push_vld, a_push_rdy, a_pop_vld, a_pop_rdy, a_wen, a_ren;
  logic [W-1:0] a_push_data, a_pop_data, a_wdata, a_rdata;
  logic [3:0]   a_waddr, a_raddr;
  logic [W-1:0] a_mem [16];

  sram1r1w_fifo_ctrl #(.N(16), .W(W)) u_a (
    .clk(clk), .arst_n(arst_n),
    .i_push_vld(a_push_vld), .i_push_data(a_push_data), .o_push_rdy(a_push_rdy),
    .o_pop_vld(a_pop_vld), .o_pop_data(a_pop_data), .i_pop_rdy(a_pop_rdy),
    .o_sram_wen(a_wen), .o_sram_waddr(a_waddr), .o_sram_wdata(a_wdata),
    .o_sram_ren(a_ren), .o_sram_raddr(a_raddr), .i_sram_rdata(a_rdata)
  );

  always @(posedge clk) begin
    if (a_wen) a_mem[a_waddr] <= a_wdata;
    if (a_ren) a_rdata <= a_mem[a_raddr];
  end

  // ---- instance B: N=5
  logic         b_push_vld, b_push_rdy, b_pop_vld, b_pop_rdy, b_wen, b_ren;
  logic [W-1:0] b_push_data, b_pop_data, b_wdata, b_rdata;
  logic [2:0]   b_waddr, b_raddr;
  logic [W-1:0] b_mem [5];

  sram1r1w_fifo_ctrl #(.N(5), .W(W)) u_b (
    .clk(clk), .arst_n(arst_n),
    .i_push_vld(b_push_vld), .i_push_data(b_push_data), .o_push_rdy(b_push_rdy),
    .o_pop_vld(b_pop_vld), .o_pop_data(b_pop_data), .i_pop_rdy(b_pop_rdy),
    .o_sram_wen(b_wen), .o_sram_waddr(b_waddr), .o_sram_wdata(b_wdata),
    .o_sram_ren(b_ren), .o_sram_raddr(b_raddr), .i_sram_rdata(b_rdata)
  );

  always @(posedge clk) begin
    if (b_wen) b_mem[b_waddr] <= b_wdata;
    if (b_ren) b_rdata <= b_mem[b_raddr];
  end

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] a_q [$];
  logic [W-1:0] b_q [$];
  logic a_acc, a_popd;
  int   b_wp = 0, b_rp = 0, b_sent = 0, b_recv = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One cycle on A: drive at negedge, sample 1ns later, run the scoreboard.
  task automatic a_step(input logic pv, input logic [W-1:0] pd, input logic pr);
    @(negedge clk);
    a_push_vld = pv; a_push_data = pd; a_pop_rdy = pr;
    #1;
    a_acc  = a_push_vld & a_push_rdy;
    a_popd = a_pop_vld & a_pop_rdy;
    chk("a_obuf_inv", {63'd0, (u_a.obuf_cnt <= 2'd3) &&
        !(u_a.inflight && u_a.obuf_cnt == 2'd3 && !a_popd)}, 64'd1);
    if (a_acc) a_q.push_back(pd);
    if (a_popd) begin
      if (a_q.size() == 0) chk("a_pop_unexpected", 64'd1, 64'd0);
      else chk("a_pop_data", a_pop_data, a_q.pop_front());
    end
  endtask

  task automatic b_step(input logic pv, input logic [W-1:0] pd, input logic pr);
    @(negedge clk);
    b_push_vld = pv; b_push_data = pd; b_pop_rdy = pr;
    #1;
    if (b_wen) begin
      chk("b_waddr", b_waddr, b_wp);
      b_wp = (b_wp == 4) ? 0 : b_wp + 1;
      b_q.push_back(pd);
      b_sent++;
    end
    if (b_ren) begin
      chk("b_raddr", b_raddr, b_rp);
      b_rp = (b_rp == 4) ? 0 : b_rp + 1;
    end
    if (b_pop_vld && b_pop_rdy) begin
      b_recv++;
      if (b_q.size() == 0) chk("b_pop_unexpected", 64'd1, 64'd0);
      else chk("b_pop_data", b_pop_data, b_q.pop_front());
    end
  endtask

  initial begin
    int acc;
    arst_n = 1'b1;
    a_push_vld = 0; a_push_data = '0; a_pop_rdy = 0;
    b_push_vld = 0; b_push_data = '0; b_pop_rdy = 0;

    // Reset asserted mid-clock, held 3 cycles.
    #2 arst_n = 1'b0;
    #1;
    chk("rst_pop_vld", a_pop_vld, 0);
    chk("rst_push_rdy", a_push_rdy, 1);
    chk("rst_wen", a_wen, 0);
    chk("rst_ren", a_ren, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #2 arst_n = 1'b1;
    a_step(0, '0, 0);
    chk("idle_pop_vld", a_pop_vld, 0);
    chk("idle_push_rdy", a_push_rdy, 1);
    chk("idle_wen", a_wen, 0);
    chk("idle_ren", a_ren, 0);

    // Single-word latency.
    a_step(1, 32'hDEADBEEF, 1);
    chk("lat_wen", a_wen, 1);
    chk("lat_waddr", a_waddr, 0);
    chk("lat_wdata", a_wdata, 32'hDEADBEEF);
    a_step(0, '0, 1);
    chk("lat_ren_t1", a_ren, 1);
    chk("lat_raddr_t1", a_raddr, 0);
    chk("lat_vld_t1", a_pop_vld, 0);
    a_step(0, '0, 1);
    chk("lat_ren_t2", a_ren, 0);
    chk("lat_vld_t2", a_pop_vld, 0);
    a_step(0, '0, 1);
    chk("lat_vld_t3", a_pop_vld, 1);
    chk("lat_data_t3", a_pop_data, 32'hDEADBEEF);
    a_step(0, '0, 1);
    chk("lat_vld_t4", a_pop_vld, 0);

    // Fill to full with the consumer stalled: capacity 16 + 3.
    acc = 0;
    for (int c = 0; c < 60 && acc < 19; c++) begin
      a_step(1, 32'(acc), 0);
      if (a_acc) acc++;
    end
    chk("fill_accepted", acc, 19);
    a_step(1, 32'h99, 0);
    chk("full_push_rdy", a_push_rdy, 0);
    chk("full_wen", a_wen, 0);
    chk("full_pop_vld", a_pop_vld, 1);
    for (int c = 0; c < 60 && a_q.size() > 0; c++) a_step(0, '0, 1);
    chk("drain_left", a_q.size(), 0);
    a_step(0, '0, 0);
    chk("drain_pop_vld", a_pop_vld, 0);

    // Full with simultaneous pop and push: push refused, ready next cycle.
    acc = 0;
    for (int c = 0; c < 60 && acc < 19; c++) begin
      a_step(1, 32'(100 + acc), 0);
      if (a_acc) acc++;
    end
    chk("refill_accepted", acc, 19);
    a_step(1, 32'd200, 1);
    chk("fp_push_rdy", a_push_rdy, 0);
    chk("fp_wen", a_wen, 0);
    chk("fp_pop_data", a_pop_data, 100);
    chk("fp_ren", a_ren, 1);
    a_step(1, 32'd200, 0);
    chk("fp_rdy_next", a_push_rdy, 1);
    chk("fp_wen_next", a_wen, 1);
    for (int c = 0; c < 60 && a_q.size() > 0; c++) a_step(0, '0, 1);
    chk("fp_drain_left", a_q.size(), 0);
    a_step(0, '0, 0);

    // Streaming: 200 words, pop every cycle after the 3-cycle prime.
    for (int c = 0; c < 203; c++) begin
      a_step(c < 200, 32'(1000 + c), 1);
      if (c >= 3) chk("stream_vld", a_pop_vld, 1);
    end
    chk("stream_left", a_q.size(), 0);

    // Asynchronous reset mid-burst.
    for (int c = 0; c < 5; c++) a_step(1, 32'(500 + c), 0);
    @(negedge clk); #2;
    arst_n = 1'b0; a_push_vld = 0;
    #1;
    chk("mrst_pop_vld", a_pop_vld, 0);
    chk("mrst_push_rdy", a_push_rdy, 1);
    chk("mrst_wen", a_wen, 0);
    chk("mrst_ren", a_ren, 0);
    a_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk); #2 arst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      a_step(0, '0, 1);
      chk("mrst_stale_vld", a_pop_vld, 0);
      chk("mrst_stale_ren", a_ren, 0);
    end
    a_step(1, 32'h55, 1);
    chk("mrst_waddr", a_waddr, 0);
    for (int c = 0; c < 6; c++) a_step(0, '0, 1);
    chk("mrst_after_left", a_q.size(), 0);

    // N=5 wrap with random stalls.
    for (int c = 0; c < 800 && (b_sent < 23 || b_q.size() > 0); c++) begin
      b_step((b_sent < 23) && ($urandom_range(0, 9) < 7), 32'(32'h5000 + b_sent),
             $urandom_range(0, 9) < 6);
    end
    b_step(0, '0, 0);
    chk("wrap_sent", b_sent, 23);
    chk("wrap_recv", b_recv, 23);
    chk("wrap_left", b_q.size(), 0);
    chk("wrap_wp", b_wp, 3);
    chk("wrap_rp", b_rp, 3);
    chk("wrap_pop_vld", b_pop_vld, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
